apb_slave_mem: RTL and testbench

- APB3 completer sitting directly downstream of the APB master BFM on one PSEL slot.
- Word-addressed memory plus one control register.
- Wait states are programmable at run time; PSLVERR can be injected.
- Used to exercise the master BFM's PREADY/PSLVERR handling in directed regressions.

---
 rtl/apb_slave_mem.sv | 167 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed memory plus a CTRL register (wait states, PSLVERR injection).
// Define APB_SLV_PSTRB_EN to add PSTRB byte-lane write strobes.
module apb_slave_mem #(
    parameter int AWIDTH       = 12,
    parameter int DEPTH        = 256,
    parameter int WAIT_DEFAULT = 0
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [3:0]  PSTRB,
`endif
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  ERR_COUNT,
    output logic        PROT_ERR
);
    localparam int IW = AWIDTH - 2;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] CTRL_IDX  = '1;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);
    localparam logic [3:0]    WAIT_RST  = 4'(WAIT_DEFAULT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] lat_idx;
    logic          lat_write;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_strb;
    logic          lat_err;
    logic          lat_inj;
    logic [3:0]    ctrl_waits;
    logic          ctrl_inj;
    logic [31:0]   mem [DEPTH];

    logic [3:0] setup_strb;
`ifdef APB_SLV_PSTRB_EN
    assign setup_strb = PSTRB;
`else
    assign setup_strb = 4'hF;
`endif

    logic [IW-1:0] paddr_idx;
    logic          setup, access, setup_err;
    logic          unused_paddr;
    assign paddr_idx    = PADDR[AWIDTH-1:2];
    assign unused_paddr = ^{PADDR[31:AWIDTH], PADDR[1:0]};
    assign setup        = PSEL && !PENABLE;
    assign access       = PSEL && PENABLE;
    assign setup_err    = (paddr_idx >= DEPTH_IDX && paddr_idx != CTRL_IDX) || ctrl_inj;

    logic commit, commit_ctrl, commit_mem;
    assign commit      = (state == DONE) && access && lat_write && !lat_err;
    assign commit_ctrl = commit && (lat_idx == CTRL_IDX);
    assign commit_mem  = commit && (lat_idx != CTRL_IDX);

    // Response data is captured on the edge that enters DONE: from the live bus when
    // coming straight from IDLE, otherwise from the latched transfer.
    logic [IW-1:0] rd_idx;
    logic          rd_write, rd_err;
    logic [31:0]   resp_data;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_idx    = lat_idx;
        rd_write  = lat_write;
        rd_err    = lat_err;
        resp_data = '0;
        if (state == IDLE) begin
            rd_idx   = paddr_idx;
            rd_write = PWRITE;
            rd_err   = setup_err;
        end
        if (!rd_write && !rd_err) begin
            if (rd_idx == CTRL_IDX) resp_data = {23'b0, ctrl_inj, 4'b0, ctrl_waits};
            else                    resp_data = mem[rd_idx[MW-1:0]];
        end
    end

    // NOTE: the memory array has no reset; contents survive PRESETN by design.
    always_ff @(posedge PCLK) begin
        if (commit_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_strb[b]) mem[lat_idx[MW-1:0]][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_wdata  <= '0;
            lat_strb   <= '0;
            lat_err    <= 1'b0;
            lat_inj    <= 1'b0;
            ctrl_waits <= WAIT_RST;
            ctrl_inj   <= 1'b0;
            PRDATA     <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            ERR_COUNT  <= '0;
            PROT_ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        lat_idx   <= paddr_idx;
                        lat_write <= PWRITE;
                        lat_wdata <= PWDATA;
                        lat_strb  <= setup_strb;
                        lat_err   <= setup_err;
                        lat_inj   <= ctrl_inj;
                        cnt       <= ctrl_waits;
                        if (ctrl_waits == 4'd0) begin
                            state   <= DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= setup_err;
                            PRDATA  <= resp_data;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (access) begin
                        PROT_ERR <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state    <= IDLE;
                        PROT_ERR <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state   <= DONE;
                        PREADY  <= 1'b1;
                        PSLVERR <= lat_err;
                        PRDATA  <= resp_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (!access) begin
                        PROT_ERR <= 1'b1;
                    end else begin
                        if (commit_ctrl && lat_strb[0]) ctrl_waits <= lat_wdata[3:0];
                        if (commit_ctrl && lat_strb[1]) ctrl_inj <= lat_wdata[8];
                        else if (lat_inj)               ctrl_inj <= 1'b0;
                        if (PSLVERR && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: directed scenarios plus randomized APB traffic, all checked
// every cycle against a transfer-level model of the completer.
module tb_apb_slave_mem;
    localparam int AWIDTH       = 12;
    localparam int DEPTH        = 256;
    localparam int WAIT_DEFAULT = 0;
    localparam int CTRL_W       = (1 << (AWIDTH - 2)) - 1;
    localparam logic [31:0] CTRL_ADDR = 32'hFFC;
`ifdef APB_SLV_PSTRB_EN
    localparam bit PSTRB_EN = 1'b1;
`else
    localparam bit PSTRB_EN = 1'b0;
`endif

    logic        PCLK = 1'b0, PRESETN = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  pstrb = 4'hF;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, PROT_ERR;
    logic [7:0]  ERR_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .WAIT_DEFAULT(WAIT_DEFAULT)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .ERR_COUNT(ERR_COUNT), .PROT_ERR(PROT_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: memory image, CTRL fields, counters and the transfer in flight.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_waits, m_err_count;
    bit          m_inj, m_prot_err;
    bit          t_active, t_err, t_inj, t_write, t_ctrl;
    int          t_k, t_waits, t_idx;
    logic [31:0] t_wdata;
    logic [3:0]  t_strb;
    bit          exp_ready, exp_known;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        m_waits = WAIT_DEFAULT; m_inj = 0; m_err_count = 0; m_prot_err = 0;
        t_active = 0; exp_ready = 0;
    endtask

    task automatic model_start();
        t_idx   = int'(PADDR[AWIDTH-1:2]);
        t_ctrl  = (t_idx == CTRL_W);
        t_err   = (!t_ctrl && t_idx >= DEPTH) || m_inj;
        t_inj   = m_inj;
        t_write = PWRITE;
        t_wdata = PWDATA;
        t_strb  = PSTRB_EN ? pstrb : 4'hF;
        t_waits = m_waits;
        t_k     = 0;
        t_active = 1;
        exp_known = 1;
        if (t_write || t_err) exp_rdata = '0;
        else if (t_ctrl) exp_rdata = (m_inj ? 32'h100 : 32'h0) | 32'(m_waits);
        else begin
            exp_rdata = m_mem[t_idx];
            exp_known = m_known[t_idx];
        end
        exp_ready = (t_waits == 0);
    endtask

    task automatic model_complete();
        if (t_write && !t_err) begin
            if (t_ctrl) begin
                if (t_strb[0]) m_waits = int'(t_wdata[3:0]);
                if (t_strb[1]) m_inj = t_wdata[8];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (t_strb[b]) m_mem[t_idx][8*b +: 8] = t_wdata[8*b +: 8];
                m_known[t_idx] = 1;
            end
        end
        if (t_inj) m_inj = 0;
        if (t_err && m_err_count < 255) m_err_count++;
    endtask

    // Advance the model by one clock using the bus inputs of the cycle just checked.
    task automatic model_step();
        if (t_active) begin
            t_k++;
            if (!(PSEL && PENABLE)) begin
                t_active = 0; m_prot_err = 1; exp_ready = 0;
            end else if (t_k == t_waits + 1) begin
                model_complete();
                t_active = 0; exp_ready = 0;
            end else begin
                exp_ready = (t_k + 1 == t_waits + 1);
            end
        end else begin
            exp_ready = 0;
            if (PSEL && !PENABLE) model_start();
            else if (PSEL && PENABLE) m_prot_err = 1;
        end
    endtask

    always @(negedge PCLK) begin
        if (!PRESETN) begin
            check("rst_pready", PREADY, 0);
            check("rst_pslverr", PSLVERR, 0);
            check("rst_prdata", PRDATA, 0);
            check("rst_err_count", ERR_COUNT, 0);
            check("rst_prot_err", PROT_ERR, 0);
            model_reset();
        end else begin
            check("pready", PREADY, exp_ready);
            if (exp_ready) begin
                if (exp_known) check("prdata", PRDATA, exp_rdata);
                check("pslverr", PSLVERR, exp_ready ? t_err : 1'b0);
            end
            check("err_count", ERR_COUNT, m_err_count);
            check("prot_err", PROT_ERR, m_prot_err);
            model_step();
        end
    end

    task automatic idle(input int n);
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        repeat (n - 1) @(posedge PCLK);
    endtask

    // One APB transfer; returns on the negedge of the PREADY cycle so a following call
    // drives its setup phase back-to-back.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic slverr, output int acc);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = wdata; pstrb = strb;
        @(posedge PCLK); #1;
        PENABLE = 1;
        acc = 0; rdata = '0; slverr = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            acc++;
            if (PREADY) begin
                rdata = PRDATA; slverr = PSLVERR;
                return;
            end
        end
        n_checks++; n_errors++;
        $display("FAIL xfer_timeout: no PREADY within 40 cycles, addr=0x%08h", addr);
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, a, d;
        logic        se, w;
        int          acc, sel;

        #1 PRESETN = 0;
        repeat (3) @(posedge PCLK);
        #2 PRESETN = 1;

        // Reset defaults: zero wait states, two-cycle transfers.
        xfer(32'h010, 1, 32'hDEADBEEF, 4'hF, rd, se, acc);
        check("t1_wr_acc", acc, 1);
        check("t1_wr_slverr", se, 0);
        xfer(32'h010, 0, 32'h0, 4'hF, rd, se, acc);
        check("t1_rd_data", rd, 32'hDEADBEEF);
        check("t1_rd_acc", acc, 1);

        // Wait states: the CTRL write itself still uses the old WAITS.
        xfer(CTRL_ADDR, 1, 32'h5, 4'hF, rd, se, acc);
        check("t2_ctrl_wr_acc", acc, 1);
        xfer(32'h010, 0, 32'h0, 4'hF, rd, se, acc);
        check("t2_rd_acc", acc, 6);
        check("t2_rd_data", rd, 32'hDEADBEEF);
        xfer(CTRL_ADDR, 0, 32'h0, 4'hF, rd, se, acc);
        check("t2_ctrl_rd", rd, 32'h5);
        xfer(CTRL_ADDR, 1, 32'h0, 4'hF, rd, se, acc);

        // Out of range: W=512 must not alias onto word 0.
        xfer(32'h000, 1, 32'hA5A50000, 4'hF, rd, se, acc);
        xfer(32'h800, 1, 32'h12345678, 4'hF, rd, se, acc);
        check("t3_slverr", se, 1);
        idle(1);
        @(negedge PCLK);
        check("t3_err_count", ERR_COUNT, 1);
        xfer(32'h000, 0, 32'h0, 4'hF, rd, se, acc);
        check("t3_word0", rd, 32'hA5A50000);

        // Error injection is consumed by exactly one transfer.
        xfer(CTRL_ADDR, 1, 32'h100, 4'hF, rd, se, acc);
        xfer(32'h010, 0, 32'h0, 4'hF, rd, se, acc);
        check("t4_inj_slverr", se, 1);
        check("t4_inj_data", rd, 0);
        xfer(32'h010, 0, 32'h0, 4'hF, rd, se, acc);
        check("t4_after_slverr", se, 0);
        check("t4_after_data", rd, 32'hDEADBEEF);
        xfer(CTRL_ADDR, 0, 32'h0, 4'hF, rd, se, acc);
        check("t4_ctrl_inj_clr", rd, 0);

        // Protocol abort: PSEL dropped in the second access cycle of a WAITS=3 write.
        xfer(CTRL_ADDR, 1, 32'h3, 4'hF, rd, se, acc);
        xfer(32'h020, 1, 32'h0BADF00D, 4'hF, rd, se, acc);
        check("t5_wr_acc", acc, 4);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 32'h020; PWRITE = 1; PWDATA = 32'hFFFFFFFF;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("t5_prot_err", PROT_ERR, 1);
        xfer(32'h020, 0, 32'h0, 4'hF, rd, se, acc);
        check("t5_no_write", rd, 32'h0BADF00D);

        // Asynchronous reset in the middle of a wait phase.
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 32'h010; PWRITE = 0;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #3 PRESETN = 0;
        #1;
        check("t5_rst_pready", PREADY, 0);
        check("t5_rst_err_count", ERR_COUNT, 0);
        check("t5_rst_prot_err", PROT_ERR, 0);
        PSEL = 0; PENABLE = 0;
        repeat (2) @(posedge PCLK);
        #2 PRESETN = 1;
        xfer(CTRL_ADDR, 0, 32'h0, 4'hF, rd, se, acc);
        check("t5_ctrl_default", rd, WAIT_DEFAULT);
        check("t5_ctrl_acc", acc, WAIT_DEFAULT + 1);
        xfer(32'h020, 0, 32'h0, 4'hF, rd, se, acc);
        check("t5_mem_kept", rd, 32'h0BADF00D);

        // Fill memory, then randomized traffic checked by the model.
        for (int i = 0; i < DEPTH; i++)
            xfer(32'(i * 4), 1, $urandom, 4'hF, rd, se, acc);
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 15);
            w   = $urandom_range(0, 1);
            d   = $urandom;
            if (sel == 0) begin
                a = CTRL_ADDR;
                d[3:0] = 4'($urandom_range(0, 3));
                d[8]   = ($urandom_range(0, 7) == 0);
            end else if (sel == 1) begin
                a = 32'($urandom_range(DEPTH, CTRL_W - 1)) << 2;
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            end
            a[31:AWIDTH] = 20'($urandom);
            a[1:0]       = 2'($urandom);
            xfer(a, w, d, PSTRB_EN ? 4'($urandom) : 4'hF, rd, se, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Saturation of the error counter.
        xfer(CTRL_ADDR, 1, 32'h0, 4'hF, rd, se, acc);
        for (int n = 0; n < 300; n++)
            xfer(32'h800 + 32'(n % 64) * 4, n[0], $urandom, 4'hF, rd, se, acc);
        idle(1);
        @(negedge PCLK);
        check("t7_err_sat", ERR_COUNT, 255);

`ifdef APB_SLV_PSTRB_EN
        xfer(32'h040, 1, 32'h11111111, 4'hF, rd, se, acc);
        xfer(32'h040, 1, 32'hAABBCCDD, 4'b0101, rd, se, acc);
        xfer(32'h040, 0, 32'h0, 4'b0000, rd, se, acc);
        check("t8_pstrb_merge", rd, 32'h11BB11DD);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
